// File: rtl/riscv_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply and divide units.
package riscv_muldiv_pkg;

    localparam int unsigned OPERAND_SIZE = 32;

    // funct3[1:0] of the multiply group
    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_CALC,
        MUL_FIX,
        MUL_DONE
    } mul_state_t;

    // rs1 is signed for MULH and MULHSU
    function automatic logic rs1_is_signed(input logic [1:0] op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    endfunction

    // rs2 is signed for MULH only
    function automatic logic rs2_is_signed(input logic [1:0] op);
        return (op == MUL_OP_MULH);
    endfunction

endpackage

// File: rtl/int_mul_32_cond_negate.sv
// Two's-complement negator: passes the input through unless enabled.
module cond_negate
    import riscv_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = OPERAND_SIZE
) (
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // negate (invert plus one, wrapping) when enabled
    always_comb begin
        dout = en ? (~din + WIDTH'(1)) : din;
    end

endmodule

// File: rtl/int_mul_32.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Works on operand magnitudes and fixes the sign after N steps.
// All state updates on the falling clock edge, matching the divider.
module int_mul_32
    import riscv_muldiv_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [1:0]              op_i,
    input  logic [OPERAND_SIZE-1:0] multiplicand_i,
    input  logic [OPERAND_SIZE-1:0] multiplier_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [OPERAND_SIZE-1:0] result_o
);

    localparam int unsigned N     = OPERAND_SIZE;
    localparam int unsigned CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    mul_state_t       state_q;
    mul_state_t       state_d;
    logic [1:0]       op_q;
    logic [N-1:0]     mcand_q;
    logic [2*N-1:0]   prod_q;
    logic             neg_q;
    logic [CNT_W-1:0] cnt_q;

    logic             rs1_neg;
    logic             rs2_neg;
    logic [N-1:0]     rs1_abs;
    logic [N-1:0]     rs2_abs;
    logic [N:0]       upper;
    logic [2*N-1:0]   prod_step;
    logic [2*N-1:0]   prod_fix;

    assign rs1_neg = rs1_is_signed(op_i) & multiplicand_i[N-1];
    assign rs2_neg = rs2_is_signed(op_i) & multiplier_i[N-1];

    // magnitude of rs1; 2^(N-1) fits in the unsigned register
    cond_negate #(.WIDTH(N)) u_abs_rs1 (
        .en   (rs1_neg),
        .din  (multiplicand_i),
        .dout (rs1_abs)
    );

    cond_negate #(.WIDTH(N)) u_abs_rs2 (
        .en   (rs2_neg),
        .din  (multiplier_i),
        .dout (rs2_abs)
    );

    // final sign correction of the full product
    cond_negate #(.WIDTH(2 * N)) u_fix (
        .en   (neg_q),
        .din  (prod_q),
        .dout (prod_fix)
    );

    // one shift-add step: add multiplicand to the upper half, keep the carry
    always_comb begin
        upper     = {1'b0, prod_q[2*N-1:N]} + {1'b0, mcand_q & {N{prod_q[0]}}};
        prod_step = {upper, prod_q[N-1:1]};
    end

    // state register
    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            state_q <= MUL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (start_i) state_d = MUL_CALC;
            MUL_CALC: if (cnt_q == CNT_LAST) state_d = MUL_FIX;
            MUL_FIX:  state_d = MUL_DONE;
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    // status outputs
    always_comb begin
        busy_o = (state_q != MUL_IDLE);
        done_o = (state_q == MUL_DONE);
    end

    // datapath; the result is taken from the sign-fixed product so it is
    // already registered when DONE is entered
    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            op_q     <= MUL_OP_MUL;
            mcand_q  <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_o <= '0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (start_i) begin
                        op_q    <= op_i;
                        mcand_q <= rs1_abs;
                        prod_q  <= {{N{1'b0}}, rs2_abs};
                        neg_q   <= rs1_neg ^ rs2_neg;
                        cnt_q   <= '0;
                    end
                end
                MUL_CALC: begin
                    prod_q <= prod_step;
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                MUL_FIX: begin
                    prod_q   <= prod_fix;
                    result_o <= (op_q == MUL_OP_MUL) ? prod_fix[N-1:0]
                                                     : prod_fix[2*N-1:N];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_mul_32.sv
// Scoreboard bench for int_mul_32: expected results are queued at start
// and compared on every done pulse.
module tb_int_mul_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp;

    int_mul_32 dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .op_i           (op),
        .multiplicand_i (a),
        .multiplier_i   (b),
        .busy_o         (busy),
        .done_o         (done),
        .result_o       (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // reference product via 64-bit sign/zero extension
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ex;
        logic [63:0] ey;
        logic [63:0] p;
        ex = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'b0, x};
        ey = (o == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
        p  = ex * ey;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // compare each completion against the scoreboard (sampled on posedge,
    // away from the active falling edge)
    always @(posedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) check("spurious_done", {31'b0, done}, 32'd0);
            else check("result", result, exp_q.pop_front());
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input int hold);
        int n;
        @(posedge clk);
        start = 1'b1; op = o; a = x; b = y;
        exp_q.push_back(exp);
        @(posedge clk);
        if (hold == 0) start = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        check("busy_rise", {31'b0, busy}, 32'd1);
        n = 1;
        while (!done && n < 100) begin
            @(posedge clk);
            n++;
            if (n == hold) start = 1'b0;
            if (!done) begin
                check("busy_during", {31'b0, busy}, 32'd1);
                check("result_hold", result, last_exp);
            end
        end
        start = 1'b0;
        if (!done) check("done_timeout", {31'b0, done}, 32'd1);
        check("latency", 32'(n - 1), 32'd33);
        check("busy_at_done", {31'b0, busy}, 32'd1);
        last_exp = exp;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; last_exp = '0;
        repeat (3) @(posedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;

        do_op(2'b00, 32'd7, 32'd6, 32'h0000002A, 0);
        do_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        do_op(2'b01, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 0);
        do_op(2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 0);
        do_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 0);
        do_op(2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 0);
        do_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        do_op(2'b01, 32'h00000000, 32'h80000000, 32'h00000000, 0);

        // start held high well into CALC must not queue a second op
        do_op(2'b11, 32'h12345678, 32'h9ABCDEF0, model(2'b11, 32'h12345678, 32'h9ABCDEF0), 20);
        @(posedge clk);
        check("no_requeue", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom); rx = $urandom; ry = $urandom;
            do_op(ro, rx, ry, model(ro, rx, ry), 0);
        end

        // reset during CALC step 10 aborts with no done pulse
        @(posedge clk);
        start = 1'b1; op = 2'b00; a = 32'd11; b = 32'd13;
        exp_q.push_back(32'd143);
        @(posedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        rst = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        last_exp = '0;

        // reset together with start drops the start
        rst = 1'b1; start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd2;
        @(posedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        check("rst_start_busy", {31'b0, busy}, 32'd0);
        repeat (40) @(posedge clk);

        do_op(2'b00, 32'd3, 32'd5, 32'h0000000F, 0);
        repeat (3) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_mul_32.md
# int_mul_32

Iterative radix-2 shift-add integer multiplier for the RV32M multiply group (MUL, MULH, MULHSU, MULHU). It is the counterpart of the iterative integer divider and sits beside it in the execute stage. It accepts one operation per start pulse and computes one partial-product step per cycle. It returns the selected 32-bit half of the 64-bit product with a one-cycle done pulse.

## Interface
- OPERAND_SIZE, 32, operand and result width; product width is 2*OPERAND_SIZE
- clk_i  input  1  clock; all registers update on the falling edge, same as the divider
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request; sampled only in IDLE
- op_i  input  2  operation, equal to funct3[1:0]: 00 MUL (low half), 01 MULH (s×s, high), 10 MULHSU (s×u, high), 11 MULHU (u×u, high)
- multiplicand_i  input  OPERAND_SIZE  operand rs1; captured with start
- multiplier_i  input  OPERAND_SIZE  operand rs2; captured with start
- busy_o  output  1  high whenever state ≠ IDLE
- done_o  output  1  one-cycle pulse; result_o is valid in this cycle
- result_o  output  OPERAND_SIZE  registered result; holds until the next completion

## Operation
- States: IDLE → CALC → FIX → DONE → IDLE.
- IDLE, start_i=1:
  - Capture the op.
  - Signedness: rs1 is signed for ops 01 and 10; rs2 is signed for op 01 only. Op 00 is treated as unsigned, since the low half is identical either way.
  - mcand_q ← |rs1| when rs1 is signed and negative, else rs1. An N-bit unsigned register holds 2^(N-1) exactly.
  - prod_q (2N bits) ← {0, |rs2|}, with the same rule applied to rs2.
  - neg_q ← sign(rs1)&signed1 XOR sign(rs2)&signed2.
  - cnt_q ← 0; go to CALC.
- IDLE, start_i=0: hold all state.
- CALC, each cycle:
  - upper = prod_q[2N-1:N] + (prod_q[0] ? mcand_q : 0), computed at N+1 bits.
  - prod_q ← {upper, prod_q[N-1:1]}, i.e. a right shift that keeps the carry.
  - cnt_q increments. Leave CALC for FIX after the step with cnt_q = N-1, so exactly N steps run.
- FIX: prod_q ← neg_q ? (~prod_q + 1) : prod_q, at 2N-bit wrap. A zero product stays zero.
- DONE:
  - result_o ← prod_q[N-1:0] for op 00, else prod_q[2N-1:N]. result_o is registered on entry to DONE.
  - done_o = 1 for this single cycle; the next state is IDLE.
- There is no early termination. Latency is fixed and independent of the data.
- start_i is ignored in CALC, FIX and DONE. It is never queued.
- Operand inputs are only sampled on the accepting edge and may change afterwards.

## Timing
- Start sampled at edge k. CALC covers edges k+1 through k+N. FIX is at edge k+N+1. done_o is high between edges k+N+1 and k+N+2.
  - For N=32 this is 33 cycles from acceptance to done.
- busy_o rises the cycle after acceptance and falls together with done_o.
- The earliest back-to-back start is the first IDLE cycle after DONE. Throughput is one op per N+3 cycles.
- Reset values: busy_o=0, done_o=0, result_o=0. Internal state: IDLE, cnt_q=0, prod_q=0, mcand_q=0, neg_q=0.
- Reset mid-operation (any state):
  - Abort at the next edge and return to IDLE with all outputs at their reset values.
  - No done_o pulse is produced for the aborted op.
- rst_i and start_i together: reset wins and the start is dropped.

## Structure
- Shared package riscv_muldiv_pkg holds:
  - Op encodings MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHSU and MUL_OP_MULHU.
  - The state enum mul_state_t.
  - The width constant OPERAND_SIZE. The divider also imports this package.
- cnt_q width is $clog2(OPERAND_SIZE).
- One sub-module is natural: cond_negate, a parameterised-width two's-complement negator controlled by an enable input.
  - It is instantiated for the operand absolute values at N bits and for the FIX step at 2N bits.

## Test plan
- Basic MUL, low half:
  - MUL 7×6 → result_o=0x0000002A, with done_o 33 cycles after the accepting edge.
  - busy_o stays high throughout the operation.
- High halves with negative and all-ones operands:
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULH 0xFFFFFFFE×3 (−2×3) → 0xFFFFFFFF.
  - MUL of the same operands → 0xFFFFFFFA.
- Corner operands:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MUL of the same operands → 0x00000000.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - MULH 0×0x80000000 → 0x00000000, with no negation artefact.
- Handshake:
  - A second start_i held high through CALC is ignored.
  - A start in the first IDLE cycle after done is accepted, and its result appears 33 cycles later.
  - result_o holds the previous value between the two completions.
- Reset mid-operation:
  - Assert rst_i for 1 cycle at CALC step 10 → busy_o=0, result_o=0, and no done_o pulse.
  - A subsequent MUL 3×5 → 0x0000000F.
